// File: rtl/cp0_if.sv
// cp0_if: groups the pipeline-facing signals of the CP0 unit.
// The pipeline side (master) drives register addresses, mtc0 data, the
// faulting PC/BD/ExcCode, hardware interrupt lines and the write/eret strobes.
// The CP0 side (slave) returns the combinational interrupt request, the EPC
// register and the register read data.
// There is no valid/ready handshake on this bus: WE and EXLClr are
// single-cycle strobes sampled on the rising clock edge. IntReq, DOut and EPC
// are level outputs that are valid whenever the inputs are stable.
interface cp0_if;
  logic [4:0]  A1;       // read register number
  logic [4:0]  A2;       // mtc0 write register number
  logic [31:0] DIn;      // mtc0 write data
  logic [31:0] PC;       // PC of the instruction taking the interrupt/exception
  logic        BD;       // that instruction sits in a branch delay slot
  logic [4:0]  ExcCode;  // internal exception code, 0 = none
  logic [5:0]  HWInt;    // hardware interrupt lines, [0] = timer
  logic        WE;       // mtc0 write enable
  logic        EXLClr;   // eret: clear EXL
  logic        IntReq;   // take interrupt/exception this cycle
  logic [31:0] EPC;      // current EPC register
  logic [31:0] DOut;     // read data for register A1

  modport master (
    output A1, A2, DIn, PC, BD, ExcCode, HWInt, WE, EXLClr,
    input  IntReq, EPC, DOut
  );

  modport slave (
    input  A1, A2, DIn, PC, BD, ExcCode, HWInt, WE, EXLClr,
    output IntReq, EPC, DOut
  );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS-style coprocessor 0 with SR (12), Cause (13), EPC (14) and
// PRId (15).
// Interrupt entry sets SR.EXL, records BD and ExcCode in Cause, and captures
// the restart address in EPC. EXL masks every further interrupt or exception
// until eret (EXLClr) clears it, so handlers never nest.
// Optional feature: define CP0_EXC_EN to accept internal exceptions through
// ExcCode. Without it, only hardware interrupts are taken and Cause.ExcCode
// always reads 0.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h2018_1215
) (
  input  logic    clk,
  input  logic    reset,
  cp0_if.slave    bus
);

  // Register numbers as seen on A1/A2.
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields.
  logic [5:0]  im_q,  im_d;    // interrupt mask, SR[15:10]
  logic        exl_q, exl_d;   // exception level, SR[1]
  logic        ie_q,  ie_d;    // global interrupt enable, SR[0]

  // Cause fields.
  logic        bd_q,  bd_d;    // branch delay flag, Cause[31]
  logic [5:0]  ip_q,  ip_d;    // interrupt pending, Cause[15:10]
  logic [4:0]  exc_q, exc_d;   // exception code, Cause[6:2]

  // EPC, always word aligned.
  logic [31:0] epc_q, epc_d;

  // Pending-event decode.
  logic        int_pend;
  logic        exc_pend;
  logic        int_req;
  logic [4:0]  exc_code_in;
  logic [31:0] pc_aligned;
  logic [31:0] entry_pc;

  // Assembled register images for the read port.
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // PC[1:0] never matter: EPC is always word aligned. ExcCode is ignored
  // entirely when internal exceptions are compiled out.
`ifdef CP0_EXC_EN
  logic unused_bits;
  assign unused_bits = ^bus.PC[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{bus.PC[1:0], bus.ExcCode};
`endif

  // Interrupt pending: any enabled line, globally enabled, not in a handler.
  always_comb begin
    int_pend = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
  end

  // Exception pending: a nonzero code outside a handler, only when the
  // exception path is compiled in.
  always_comb begin
`ifdef CP0_EXC_EN
    exc_code_in = bus.ExcCode;
    exc_pend    = (bus.ExcCode != 5'd0) & ~exl_q;
`else
    exc_code_in = 5'd0;
    exc_pend    = 1'b0;
`endif
  end

  // Restart address: a delay-slot instruction restarts at its branch.
  always_comb begin
    pc_aligned = {bus.PC[31:2], 2'b00};
    entry_pc   = bus.BD ? (pc_aligned - 32'd4) : pc_aligned;
    int_req    = int_pend | exc_pend;
  end

  // Next-state logic: entry beats mtc0 and eret; eret clears EXL after any
  // SR write on the same edge.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    // IP mirrors the interrupt lines every cycle, even inside a handler.
    ip_d  = bus.HWInt;

    if (int_req) begin
      // The interrupt wins over a simultaneous exception and records code 0.
      // Any mtc0 on this edge is dropped.
      exl_d = 1'b1;
      bd_d  = bus.BD;
      exc_d = int_pend ? 5'd0 : exc_code_in;
      epc_d = entry_pc;
    end else begin
      if (bus.WE && (bus.A2 == REG_SR)) begin
        im_d  = bus.DIn[15:10];
        exl_d = bus.DIn[1];
        ie_d  = bus.DIn[0];
      end
      if (bus.WE && (bus.A2 == REG_EPC)) begin
        epc_d = {bus.DIn[31:2], 2'b00};
      end
      if (bus.EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  // State registers. Reset clears everything and abandons any open handler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= 6'd0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= 6'd0;
      exc_q <= 5'd0;
      epc_q <= 32'd0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  // Register images with every unimplemented bit tied to zero.
  always_comb begin
    sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'b00};
  end

  // Combinational read port; unknown register numbers read 0.
  always_comb begin
    bus.DOut = 32'd0;
    case (bus.A1)
      REG_SR:    bus.DOut = sr_word;
      REG_CAUSE: bus.DOut = cause_word;
      REG_EPC:   bus.DOut = epc_q;
      REG_PRID:  bus.DOut = PRID_VALUE;
      default:   bus.DOut = 32'd0;
    endcase
  end

  // Drive the remaining outputs.
  always_comb begin
    bus.IntReq = int_req;
    bus.EPC    = epc_q;
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed scenarios followed by randomized cycles, checked
// against a word-level model of the CP0 registers.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2018_1215;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_if bus();

  cp0_unit #(.PRID_VALUE(PRID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the three architectural registers as full words.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic m_int();
    return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_exc();
`ifdef CP0_EXC_EN
    return (bus.ExcCode != 5'd0) && !m_sr[1];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_sr    = 32'd0;
    m_cause = 32'd0;
    m_epc   = 32'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  task automatic set_idle();
    bus.A1      = 5'd12;
    bus.A2      = 5'd0;
    bus.DIn     = 32'd0;
    bus.PC      = 32'd0;
    bus.BD      = 1'b0;
    bus.ExcCode = 5'd0;
    bus.HWInt   = 6'd0;
    bus.WE      = 1'b0;
    bus.EXLClr  = 1'b0;
  endtask

  // Compare all outputs against the model for the current inputs.
  task automatic check_now(input string tag);
    #1;
    check({tag, ".intreq"}, {31'd0, bus.IntReq}, {31'd0, m_int() | m_exc()});
    check({tag, ".epc"}, bus.EPC, m_epc);
    check({tag, ".dout"}, bus.DOut, m_read(bus.A1));
  endtask

  // Read one register by number and compare against a fixed value.
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.A1 = a;
    #1;
    check(tag, bus.DOut, exp);
  endtask

  // Advance one clock edge, updating the model from the inputs at that edge.
  task automatic tick();
    logic [31:0] n_sr, n_cause, n_epc;
    logic        take_int, take_exc;
    n_sr     = m_sr;
    n_cause  = m_cause;
    n_epc    = m_epc;
    take_int = m_int();
    take_exc = m_exc();
    if (take_int || take_exc) begin
      n_sr    = n_sr | 32'h2;
      n_cause = (n_cause & 32'h7FFF_FF83) | (bus.BD ? 32'h8000_0000 : 32'd0);
      if (!take_int) n_cause = n_cause | ({27'd0, bus.ExcCode} * 32'd4);
      n_epc   = (bus.PC & 32'hFFFF_FFFC) - (bus.BD ? 32'd4 : 32'd0);
    end else begin
      if (bus.WE && bus.A2 == 5'd12) n_sr  = bus.DIn & 32'h0000_FC03;
      if (bus.WE && bus.A2 == 5'd14) n_epc = bus.DIn & 32'hFFFF_FFFC;
      if (bus.EXLClr) n_sr = n_sr & ~32'h2;
    end
    n_cause = (n_cause & ~32'h0000_FC00) | ({26'd0, bus.HWInt} * 32'd1024);
    @(posedge clk);
    #1;
    m_sr    = n_sr;
    m_cause = n_cause;
    m_epc   = n_epc;
  endtask

  logic [4:0] a2_pick [5];

  initial begin
    a2_pick[0] = 5'd12; a2_pick[1] = 5'd13; a2_pick[2] = 5'd14;
    a2_pick[3] = 5'd15; a2_pick[4] = 5'd3;

    // Reset with no clock edge needed.
    reset = 1'b1;
    set_idle();
    m_reset();
    check_now("reset");
    rd("reset.sr", 5'd12, 32'd0);
    rd("reset.cause", 5'd13, 32'd0);
    rd("reset.epc", 5'd14, 32'd0);
    rd("reset.prid", 5'd15, PRID);
    rd("reset.other", 5'd7, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic interrupt entry from a normal slot.
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
    check_now("mtc0_sr");
    tick();
    set_idle();
    rd("sr_written", 5'd12, 32'h0000_0401);
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_3010; bus.BD = 1'b0;
    #1;
    check("irq.intreq", {31'd0, bus.IntReq}, 32'd1);
    check_now("irq");
    tick();
    check("irq.epc", bus.EPC, 32'h0000_3010);
    rd("irq.sr", 5'd12, 32'h0000_0403);
    rd("irq.cause", 5'd13, 32'h0000_0400);
    check("irq.masked", {31'd0, bus.IntReq}, 32'd0);

    // Delay-slot entry: EPC points at the branch.
    set_idle();
    bus.EXLClr = 1'b1;
    check_now("eret1");
    tick();
    set_idle();
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_3014; bus.BD = 1'b1;
    check_now("bd_irq");
    tick();
    check("bd.epc", bus.EPC, 32'h0000_3010);
    rd("bd.cause", 5'd13, 32'h8000_0400);

    // Lines are still sampled inside a handler but cannot interrupt it.
    set_idle();
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0C03;
    bus.HWInt = 6'b000010;
    #1;
    check("nest.intreq", {31'd0, bus.IntReq}, 32'd0);
    check_now("nest");
    tick();
    bus.WE = 1'b0;
    rd("nest.cause", 5'd13, 32'h8000_0800);
    bus.EXLClr = 1'b1;
    check_now("nest.eret");
    tick();
    bus.EXLClr = 1'b0;
    #1;
    check("nest.after_eret", {31'd0, bus.IntReq}, 32'd1);
    check_now("nest.taken");
    tick();

    // Internal exception with interrupts globally disabled.
    set_idle();
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0000; bus.EXLClr = 1'b1;
    check_now("exc.setup");
    tick();
    set_idle();
    bus.ExcCode = 5'd4; bus.PC = 32'h0000_3000;
`ifdef CP0_EXC_EN
    #1;
    check("exc.intreq", {31'd0, bus.IntReq}, 32'd1);
    tick();
    rd("exc.cause", 5'd13, 32'h0000_0010);
    check("exc.epc", bus.EPC, 32'h0000_3000);
`else
    #1;
    check("exc.intreq", {31'd0, bus.IntReq}, 32'd0);
    tick();
    check_now("exc.ignored");
`endif

    // Entry beats a same-edge mtc0 to EPC.
    set_idle();
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401; bus.EXLClr = 1'b1;
    check_now("race.setup");
    tick();
    set_idle();
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_3010;
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'hFFFF_FFFF;
    check_now("race");
    tick();
    check("race.epc", bus.EPC, 32'h0000_3010);
    rd("race.sr", 5'd12, 32'h0000_0403);

    // Asynchronous reset in the middle of a handler.
    set_idle();
    #2;
    reset = 1'b1;
    m_reset();
    rd("rst.sr", 5'd12, 32'd0);
    rd("rst.cause", 5'd13, 32'd0);
    rd("rst.epc", 5'd14, 32'd0);
    rd("rst.prid", 5'd15, PRID);
    check("rst.epc_out", bus.EPC, 32'd0);
    check("rst.intreq", {31'd0, bus.IntReq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.A1      = 5'($urandom_range(10, 16));
      bus.A2      = a2_pick[$urandom_range(0, 4)];
      bus.DIn     = $urandom();
      bus.PC      = $urandom();
      bus.BD      = 1'($urandom_range(0, 1));
      bus.ExcCode = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      bus.HWInt   = ($urandom_range(0, 2) == 0) ? 6'($urandom()) : 6'd0;
      bus.WE      = ($urandom_range(0, 2) == 0);
      bus.EXLClr  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b1;
        m_reset();
        check_now("rnd.reset");
        reset = 1'b0;
      end
      check_now("rnd");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 The block SHALL have parameter PRID_VALUE, default 32'h2018_1215, value returned on reads of PRId (reg 15).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port A1, input, 5, read register number (12 SR, 13 Cause, 14 EPC, 15 PRId).
REQ-005 The block SHALL have port A2, input, 5, write register number for mtc0.
REQ-006 The block SHALL have port DIn, input, 32, mtc0 write data.
REQ-007 The block SHALL have port PC, input, 32, address of the instruction in the stage taking the interrupt or exception.
REQ-008 The block SHALL have port BD, input, 1, that instruction is in a branch delay slot.
REQ-009 The block SHALL have port ExcCode, input, 5, internal exception code; 0 means none.
REQ-010 The block SHALL have port HWInt, input, 6, hardware interrupt lines; HWInt[0] is the timer IRQ.
REQ-011 The block SHALL have port WE, input, 1, mtc0 write enable.
REQ-012 The block SHALL have port EXLClr, input, 1, eret: clear EXL.
REQ-013 The block SHALL have port IntReq, output, 1, take interrupt or exception this cycle (combinational).
REQ-014 The block SHALL have port EPC, output, 32, current EPC register.
REQ-015 The block SHALL have port DOut, output, 32, combinational read of register A1; other numbers read 0.

Function
REQ-016 SR SHALL hold IM[15:10], EXL[1], IE[0]; all other bits read 0 and ignore writes.
REQ-017 Cause SHALL hold BD[31], IP[15:10], ExcCode[6:2]; other bits read 0; Cause is not writable by mtc0.
REQ-018 IP SHALL load HWInt every cycle, unconditionally, including while EXL=1.
REQ-019 Interrupt pending SHALL be |(HWInt & IM) & IE & ~EXL, evaluated on current register values and current HWInt.
REQ-020 Exception pending SHALL be (ExcCode != 0) & ~EXL.
REQ-021 IntReq SHALL be interrupt pending OR exception pending.
REQ-022 When IntReq=1, the next edge SHALL set EXL=1, write BD, write ExcCode (0 for interrupt), and load EPC = BD ? {PC[31:2],2'b00}-4 : {PC[31:2],2'b00}.
REQ-023 When both pending at once, the interrupt SHALL take priority and ExcCode SHALL record 0.
REQ-024 WE=1 with A2=12 SHALL write SR masked bits; A2=14 SHALL write EPC with DIn[31:2],2'b00; other A2 ignored.
REQ-025 When IntReq=1 and WE=1 on the same edge, exception entry SHALL win for EPC and EXL; the mtc0 write SHALL be discarded entirely.
REQ-026 EXLClr=1 with IntReq=0 SHALL clear EXL on the next edge; with IntReq=1 on the same edge, EXL SHALL be set.
REQ-027 EXLClr and WE to SR on the same edge SHALL apply DIn then force EXL=0.
REQ-028 EXL=1 SHALL mask all further interrupts and exceptions until cleared (no nesting).

Reset
REQ-029 On reset: SR=0 (IM=0, EXL=0, IE=0), Cause=0, EPC=0; IntReq therefore 0, DOut per A1, with no clock required.
REQ-030 Reset asserted mid-handler SHALL drop EXL and abandon the captured EPC.

Configuration
REQ-031 Macro CP0_EXC_EN defined: ExcCode input and REQ-020 active. Undefined: exception pending constant 0; only interrupts recorded; Cause.ExcCode always 0.

Verification
REQ-032 Reset; mtc0 SR=32'h0000_0401; HWInt=6'b000001, PC=32'h0000_3010, BD=0 -> IntReq=1 same cycle; next cycle EPC=32'h3010, SR=32'h0000_0403, Cause=32'h0000_0400.
REQ-033 Same as REQ-032 with BD=1, PC=32'h0000_3014 -> EPC=32'h3010, Cause[31]=1.
REQ-034 While EXL=1, raise HWInt=6'b000010 with IM enabled -> IntReq=0; Cause IP=6'b000010; after EXLClr, IntReq=1 next cycle.
REQ-035 With CP0_EXC_EN, ExcCode=5'd4, PC=32'h3000, IE=0 -> IntReq=1; next cycle Cause=32'h0000_0010, EPC=32'h3000; without macro IntReq=0.
REQ-036 IntReq=1 and WE=1,A2=14,DIn=32'hFFFF_FFFF same edge -> EPC=PC value, not 32'hFFFF_FFFC.
REQ-037 Assert reset while EXL=1 and EPC=32'h3010 -> SR, Cause, EPC read 0 immediately; A1=15 reads PRID_VALUE.
